// File: rtl/i2s_sample_buffer.sv
// i2s_sample_buffer: elastic BCLK-domain sample FIFO between the I2S deserializer
// and the serializer. It primes to PRIME_LEVEL before output starts, pops one
// sample per tx frame (on each LRCLK falling edge) and keeps sticky
// overflow/underflow flags.
module i2s_sample_buffer #(
    parameter int unsigned BIT_DEPTH     = 18,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PRIME_LEVEL   = 4,
    parameter int unsigned UNDERRUN_HOLD = 0
) (
    input  logic                     BCLK,
    input  logic                     RST_N,
    input  logic [BIT_DEPTH-1:0]     rx_data,
    input  logic                     rx_ready,
    input  logic                     tx_lrclk,
    input  logic                     clear_flags,
    output logic [BIT_DEPTH-1:0]     tx_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     primed,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   lrclk_q, lrclk_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [BIT_DEPTH-1:0]   tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   primed_q, primed_d;
    logic [BIT_DEPTH-1:0]   mem_q [DEPTH];

    logic wr_c, rd_c, run_c, empty_c, full_c;
    logic push_c, pop_c, ovf_set_c, unf_set_c;

    // Edge detection and push/pop decisions; a pop in RUN frees a slot for a same-cycle write
    always_comb begin
        wr_c      = rx_ready & ~rx_ready_q;
        rd_c      = lrclk_q & ~tx_lrclk;
        run_c     = (state_q == ST_RUN);
        empty_c   = (level_q == LVL_W'(0));
        full_c    = (level_q == LVL_W'(DEPTH));
        pop_c     = run_c & rd_c & ~empty_c;
        unf_set_c = run_c & rd_c & empty_c;
        push_c    = wr_c & (~full_c | pop_c);
        ovf_set_c = wr_c & full_c & ~pop_c;
    end

    // State register
    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: prime on the registered level, fall back to FILL on an underrun
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (level_q >= LVL_W'(PRIME_LEVEL)) state_d = ST_RUN;
            ST_RUN:  if (unf_set_c)                      state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        rx_ready_d  = rx_ready;
        lrclk_d     = tx_lrclk;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        tx_data_d   = tx_data_q;
        primed_d    = (state_d == ST_RUN);
        overflow_d  = (overflow_q & ~clear_flags) | ovf_set_c;
        underflow_d = (underflow_q & ~clear_flags) | unf_set_c;

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (pop_c) begin
            tx_data_d = mem_q[rd_ptr_q];
        end else if (unf_set_c) begin
            tx_data_d = (UNDERRUN_HOLD != 0) ? tx_data_q : '0;
        end
    end

    // Control and output registers
    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_ready_q  <= 1'b0;
            lrclk_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tx_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            rx_ready_q  <= rx_ready_d;
            lrclk_q     <= lrclk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tx_data_q   <= tx_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            primed_q    <= primed_d;
        end
    end

    // Sample storage; contents are qualified by level so no reset is needed
    always_ff @(posedge BCLK) begin
        if (push_c) mem_q[wr_ptr_q] <= rx_data;
    end

    assign tx_data   = tx_data_q;
    assign level     = level_q;
    assign primed    = primed_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
